// File: rtl/tff_bank_sequencer_if.sv
// Command handshake and T flip-flop bank signals between a host/bank pair and the sequencer.
// Handshake: a command transfers on the posedge where cmd_valid && cmd_ready; the host keeps op/arg stable until then.
interface tff_bank_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] t_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, q_in,
    input  cmd_ready, t_out, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, q_in,
    output cmd_ready, t_out, busy, done, err
  );
endinterface

// File: rtl/tff_bank_sequencer.sv
// Drives toggle enables of an external T flip-flop bank to count up/down, load or clear,
// then reads the bank back and raises a sticky error when it disagrees with the expected value.
module tff_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tff_bank_sequencer_if.slave bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_exp;
  logic             r_err;

  logic             w_accept;
  logic             w_new_step_op;
  logic             w_step_op;
  logic             w_last_step;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_carry_up;
  logic [WIDTH-1:0] w_borrow_dn;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_exp_nxt;

  assign w_accept      = bus.cmd_valid && (r_state == S_IDLE);
  assign w_new_step_op = (bus.cmd_op == OP_UP) || (bus.cmd_op == OP_DOWN);
  assign w_step_op     = (r_op == OP_UP) || (r_op == OP_DOWN);
  assign w_last_step   = (r_remaining == WIDTH'(1));
  assign w_mismatch    = (bus.q_in != r_exp);

  // A bit toggles on increment when all lower bits are 1, on decrement when all lower bits are 0.
  always_comb begin
    w_carry_up     = '0;
    w_borrow_dn    = '0;
    w_carry_up[0]  = 1'b1;
    w_borrow_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_carry_up[i]  = w_carry_up[i-1] & bus.q_in[i-1];
      w_borrow_dn[i] = w_borrow_dn[i-1] & ~bus.q_in[i-1];
    end
  end

  // Enables depend only on state, latched op and q_in, so nothing from cmd_* reaches t_out.
  always_comb begin
    w_toggle = '0;
    if (r_state == S_PULSE) begin
      case (r_op)
        OP_UP:   w_toggle = w_carry_up;
        OP_DOWN: w_toggle = w_borrow_dn;
        OP_LOAD: w_toggle = bus.q_in ^ r_target;
        default: w_toggle = bus.q_in;
      endcase
    end
  end

  always_comb begin
    w_exp_nxt = '0;
    case (r_op)
      OP_UP:   w_exp_nxt = bus.q_in + WIDTH'(1);
      OP_DOWN: w_exp_nxt = bus.q_in - WIDTH'(1);
      OP_LOAD: w_exp_nxt = r_target;
      default: w_exp_nxt = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_new_step_op && (bus.cmd_arg == '0)) w_state_nxt = S_DONE;
          else                                      w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_step_op && !w_last_step) w_state_nxt = S_PULSE;
        else                           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= OP_UP;
      r_remaining <= '0;
      r_target    <= '0;
      r_exp       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op        <= bus.cmd_op;
        r_remaining <= bus.cmd_arg;
        r_target    <= bus.cmd_arg;
        r_err       <= 1'b0;
      end
      if (r_state == S_PULSE) r_exp <= w_exp_nxt;
      // The bank has absorbed the pulse by the WAIT cycle, so q_in is compared here.
      if (r_state == S_WAIT) begin
        if (w_mismatch) r_err <= 1'b1;
        if (w_step_op)  r_remaining <= r_remaining - WIDTH'(1);
      end
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.t_out     = w_toggle;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Bench for tff_bank_sequencer: behavioural T flip-flop bank, directed scenarios plus random commands,
// scoreboard queues filled at accept and drained by a monitor on t_out pulses and done.
module tb_tff_bank_sequencer;
  localparam int W = 4;
  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LOAD = 2'b10, CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tff_bank_sequencer_if #(.WIDTH(W)) bus();
  logic [1:0] dbg_state;

  tff_bank_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Bank of T flip-flops; fault_mask lets selected bits ignore their toggle enable.
  logic [W-1:0] bank_q = '0;
  logic [W-1:0] fault_mask = '0;
  always @(posedge clk) bank_q <= bank_q ^ (bus.t_out & ~fault_mask);
  assign bus.q_in = bank_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] arg;
    logic         exp_err;
    int           exp_lat;
    int           exp_pulses;
    int           acc_cyc;
  } cmd_t;

  cmd_t         cmd_q[$];
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int last_done_cyc = 0;
  int last_acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: outcome of a whole command from the bank value it starts on.
  task automatic model(input logic [1:0] op, input logic [W-1:0] arg, input logic [W-1:0] start,
                       output logic [W-1:0] fin, output logic err, output int lat, output int pulses);
    case (op)
      UP: begin
        fin = start + arg; err = 1'b0; pulses = int'(arg);
        lat = (arg == 0) ? 1 : 2 * int'(arg) + 1;
      end
      DOWN: begin
        fin = start - arg; err = 1'b0; pulses = int'(arg);
        lat = (arg == 0) ? 1 : 2 * int'(arg) + 1;
      end
      LOAD: begin
        fin = start ^ ((start ^ arg) & ~fault_mask); err = (fin != arg);
        lat = 3; pulses = (start != arg) ? 1 : 0;
      end
      default: begin
        fin = start & fault_mask; err = (fin != '0);
        lat = 3; pulses = (start != '0) ? 1 : 0;
      end
    endcase
  endtask

  function automatic logic [W-1:0] pulse_model(input logic [1:0] op, input logic [W-1:0] arg,
                                               input logic [W-1:0] q);
    logic [W-1:0] nxt;
    case (op)
      UP:      nxt = q + 1'b1;
      DOWN:    nxt = q - 1'b1;
      LOAD:    nxt = arg;
      default: nxt = '0;
    endcase
    return q ^ nxt;
  endfunction

  always @(negedge clk) begin : monitor
    cmd_t c;
    logic [W-1:0] e;
    if (rst_n) begin
      if (bus.t_out != '0) begin
        if (cmd_q.size() == 0) check("unexpected_pulse", 32'(bus.t_out), 0);
        else begin
          check("t_out", 32'(bus.t_out), 32'(pulse_model(cmd_q[0].op, cmd_q[0].arg, bank_q)));
          pulse_cnt++;
        end
      end
      if (bus.done) begin
        if (cmd_q.size() == 0) check("unexpected_done", 32'(bus.done), 0);
        else begin
          c = cmd_q.pop_front();
          e = exp_q.pop_front();
          check("final_q", 32'(bank_q), 32'(e));
          check("err_at_done", 32'(bus.err), 32'(c.exp_err));
          check("latency", 32'(cyc - c.acc_cyc + 1), 32'(c.exp_lat));
          check("pulse_count", 32'(pulse_cnt), 32'(c.exp_pulses));
          check("ready_in_done", 32'(bus.cmd_ready), 0);
          check("busy_in_done", 32'(bus.busy), 1);
          pulse_cnt = 0;
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [W-1:0] arg, input bit hold);
    cmd_t c;
    logic [W-1:0] fin;
    int budget;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    budget = 0;
    while (!bus.cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.cmd_ready) begin
      timeout("accept");
      bus.cmd_valid = 1'b0;
      return;
    end
    c.op = op;
    c.arg = arg;
    model(op, arg, bank_q, fin, c.exp_err, c.exp_lat, c.exp_pulses);
    @(posedge clk);
    #1;
    c.acc_cyc = cyc;
    last_acc_cyc = cyc;
    cmd_q.push_back(c);
    exp_q.push_back(fin);
    if (!hold) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((cmd_q.size() != 0 || bus.busy) && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (b >= 200) timeout("wait_idle");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = UP;
    bus.cmd_arg   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_t_out", 32'(bus.t_out), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;

    send(UP, 4'd3, 1'b0);     wait_idle();
    send(LOAD, 4'hE, 1'b0);   wait_idle();
    send(UP, 4'd3, 1'b0);     wait_idle();
    send(CLEAR, 4'h0, 1'b0);  wait_idle();
    send(DOWN, 4'd2, 1'b0);   wait_idle();
    send(LOAD, 4'h5, 1'b0);   wait_idle();
    send(LOAD, 4'hA, 1'b0);   wait_idle();
    send(CLEAR, 4'h3, 1'b0);  wait_idle();
    send(LOAD, 4'h0, 1'b0);   wait_idle();

    fault_mask = 4'h4;
    send(LOAD, 4'h4, 1'b0);   wait_idle();
    fault_mask = '0;
    @(negedge clk);
    check("err_sticky", 32'(bus.err), 1);
    send(UP, 4'd1, 1'b0);
    check("err_cleared_on_accept", 32'(bus.err), 0);
    wait_idle();

    send(UP, 4'd0, 1'b0);     wait_idle();

    send(UP, 4'd5, 1'b0);
    repeat (2) @(negedge clk);
    check("pulse_before_reset", 32'(bus.t_out != '0), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_t_out", 32'(bus.t_out), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    cmd_q.delete();
    exp_q.delete();
    pulse_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_reset", 32'(bus.done), 0);
    end

    send(UP, 4'd2, 1'b1);
    send(LOAD, 4'h9, 1'b0);
    check("held_valid_gap", 32'(last_acc_cyc - last_done_cyc), 2);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), W'($urandom_range(0, 15)),
           (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
